// File: rtl/dllp_scheduler.sv
// Transmit-side DLLP scheduler: turns receiver events and flow-control timing into
// Ack, Nak and UpdateFC DLLP bodies, presented one at a time to the TX arbiter.
module dllp_scheduler #(
  parameter int ACK_LAT_LIMIT   = 64,
  parameter int ACK_COALESCE    = 4,
  parameter int FC_UPDATE_LIMIT = 512
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_tlp_good,
  input  logic        rx_tlp_bad,
  input  logic [11:0] next_rcv_seq,
  input  logic [2:0]  fc_update_req,
  input  logic [7:0]  p_hdr,
  input  logic [7:0]  np_hdr,
  input  logic [7:0]  cpl_hdr,
  input  logic [11:0] p_data,
  input  logic [11:0] np_data,
  input  logic [11:0] cpl_data,
  input  logic        dllp_ready,
  output logic        dllp_valid,
  output logic [31:0] dllp_o,
  output logic        nak_scheduled
);

  localparam int ATW = $clog2(ACK_LAT_LIMIT + 1);
  localparam int CW  = $clog2(ACK_COALESCE + 1);
  localparam int FW  = $clog2(FC_UPDATE_LIMIT);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [2:0] SEL_NAK   = 3'd0;
  localparam logic [2:0] SEL_ACK   = 3'd1;
  localparam logic [2:0] SEL_FCP   = 3'd2;
  localparam logic [2:0] SEL_FCNP  = 3'd3;
  localparam logic [2:0] SEL_FCCPL = 3'd4;

  logic [0:0]     state;
  logic [2:0]     sel;
  logic           nak_pend;
  logic           ack_pend;
  logic [2:0]     fc_pend;
  logic [CW-1:0]  tlp_cnt;
  logic [CW-1:0]  tlp_cnt_nxt;
  logic [ATW-1:0] ack_timer;
  logic [FW-1:0]  fc_timer;

  logic [11:0] seq;
  logic        bad_eff;
  logic        ack_due;
  logic        fc_wrap;
  logic        accept;
  logic        acc_nak;
  logic        acc_ack;
  logic [2:0]  acc_fc;
  logic [2:0]  fc_set;

  logic        cand_any;
  logic [2:0]  cand_sel;
  logic [31:0] cand_word;

  assign seq     = next_rcv_seq - 12'd1;
  // A bad TLP arriving alongside a good one, or while a Nak is outstanding, is dropped.
  assign bad_eff = rx_tlp_bad & ~rx_tlp_good & ~nak_scheduled;
  assign ack_due = ack_pend & ((ack_timer == ATW'(ACK_LAT_LIMIT)) |
                               (tlp_cnt == CW'(ACK_COALESCE)));
  assign fc_wrap = (fc_timer == FW'(FC_UPDATE_LIMIT - 1));
  assign accept  = (state == SEND) & dllp_valid & dllp_ready;
  assign acc_nak = accept & (sel == SEL_NAK);
  assign acc_ack = accept & (sel == SEL_ACK);
  assign acc_fc  = {accept & (sel == SEL_FCCPL), accept & (sel == SEL_FCNP),
                    accept & (sel == SEL_FCP)};
  assign fc_set  = fc_update_req | {3{fc_wrap}};

  always_comb begin
    tlp_cnt_nxt = (acc_nak | acc_ack) ? '0 : tlp_cnt;
    if (rx_tlp_good && (tlp_cnt_nxt != CW'(ACK_COALESCE)))
      tlp_cnt_nxt = tlp_cnt_nxt + CW'(1);
  end

  always_comb begin
    cand_any  = 1'b0;
    cand_sel  = SEL_NAK;
    cand_word = 32'h0;
    if (nak_pend) begin
      cand_any  = 1'b1;
      cand_sel  = SEL_NAK;
      cand_word = {8'h10, 8'h00, 4'h0, seq};
    end else if (ack_due) begin
      cand_any  = 1'b1;
      cand_sel  = SEL_ACK;
      cand_word = {8'h00, 8'h00, 4'h0, seq};
    end else if (fc_pend[0]) begin
      cand_any  = 1'b1;
      cand_sel  = SEL_FCP;
      cand_word = {8'h80, 2'b00, p_hdr, 2'b00, p_data};
    end else if (fc_pend[1]) begin
      cand_any  = 1'b1;
      cand_sel  = SEL_FCNP;
      cand_word = {8'hA0, 2'b00, np_hdr, 2'b00, np_data};
    end else if (fc_pend[2]) begin
      cand_any  = 1'b1;
      cand_sel  = SEL_FCCPL;
      cand_word = {8'hC0, 2'b00, cpl_hdr, 2'b00, cpl_data};
    end
  end

  // Pending flags: a set on the same edge as the accept-driven clear always wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nak_pend      <= 1'b0;
      ack_pend      <= 1'b0;
      fc_pend       <= 3'b000;
      tlp_cnt       <= '0;
      ack_timer     <= '0;
      fc_timer      <= '0;
      nak_scheduled <= 1'b0;
    end else begin
      nak_pend <= (nak_pend & ~acc_nak) | bad_eff;
      ack_pend <= (ack_pend & ~(acc_nak | acc_ack)) | rx_tlp_good;
      fc_pend  <= (fc_pend & ~acc_fc) | fc_set;
      tlp_cnt  <= tlp_cnt_nxt;
      fc_timer <= fc_wrap ? '0 : fc_timer + FW'(1);
      if (acc_nak | acc_ack | ~ack_pend)
        ack_timer <= '0;
      else if (ack_timer != ATW'(ACK_LAT_LIMIT))
        ack_timer <= ack_timer + ATW'(1);
      if (acc_nak)
        nak_scheduled <= 1'b1;
      else if (rx_tlp_good)
        nak_scheduled <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      sel        <= SEL_NAK;
      dllp_valid <= 1'b0;
      dllp_o     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_any) begin
            dllp_o     <= cand_word;
            sel        <= cand_sel;
            dllp_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (dllp_ready) begin
            dllp_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          dllp_valid <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dllp_scheduler.sv
// Bench for dllp_scheduler: a per-cycle event-level model checked on every falling edge,
// plus directed scenarios with hand-computed DLLP words and timings.
module tb_dllp_scheduler;

  localparam int ACK_LAT = 64;
  localparam int COAL    = 4;
  localparam int FC_LIM  = 512;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_tlp_good;
  logic        rx_tlp_bad;
  logic [11:0] next_rcv_seq;
  logic [2:0]  fc_update_req;
  logic [7:0]  p_hdr, np_hdr, cpl_hdr;
  logic [11:0] p_data, np_data, cpl_data;
  logic        dllp_ready;
  logic        dllp_valid;
  logic [31:0] dllp_o;
  logic        nak_scheduled;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] seen[$];

  bit          m_nak, m_ack, m_nsched, m_busy;
  bit [2:0]    m_fc;
  int          m_cnt, m_age, m_tick, m_kind;
  logic [31:0] m_word = 32'h0;

  always #5 clk = ~clk;

  dllp_scheduler #(
    .ACK_LAT_LIMIT(ACK_LAT),
    .ACK_COALESCE(COAL),
    .FC_UPDATE_LIMIT(FC_LIM)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_tlp_good(rx_tlp_good),
    .rx_tlp_bad(rx_tlp_bad),
    .next_rcv_seq(next_rcv_seq),
    .fc_update_req(fc_update_req),
    .p_hdr(p_hdr),
    .np_hdr(np_hdr),
    .cpl_hdr(cpl_hdr),
    .p_data(p_data),
    .np_data(np_data),
    .cpl_data(cpl_data),
    .dllp_ready(dllp_ready),
    .dllp_valid(dllp_valid),
    .dllp_o(dllp_o),
    .nak_scheduled(nak_scheduled)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // DLLP body built arithmetically from the field layout (kind 0 Nak, 1 Ack, 2..4 FC P/NP/Cpl).
  function automatic logic [31:0] fmtDllp(input int kind, input logic [11:0] s);
    case (kind)
      0:       return 32'h1000_0000 | 32'(s);
      1:       return 32'(s);
      2:       return 32'h8000_0000 | (32'(p_hdr) << 14) | 32'(p_data);
      3:       return 32'hA000_0000 | (32'(np_hdr) << 14) | 32'(np_data);
      default: return 32'hC000_0000 | (32'(cpl_hdr) << 14) | 32'(cpl_data);
    endcase
  endfunction

  task automatic modelStep();
    bit acc, accNak, accAck, good, badEff, wrap;
    int pick, base;
    if (!rst) begin
      m_nak = 0; m_ack = 0; m_nsched = 0; m_busy = 0; m_fc = 3'b000;
      m_cnt = 0; m_age = 0; m_tick = 0; m_kind = 0; m_word = 32'h0;
    end else begin
      acc    = m_busy && dllp_ready;
      accNak = acc && (m_kind == 0);
      accAck = acc && (m_kind == 1);
      good   = rx_tlp_good;
      badEff = rx_tlp_bad && !rx_tlp_good && !m_nsched;
      wrap   = (m_tick == FC_LIM - 1);
      pick   = -1;
      if (!m_busy) begin
        if (m_nak) pick = 0;
        else if (m_ack && (m_age >= ACK_LAT || m_cnt >= COAL)) pick = 1;
        else for (int t = 0; t < 3; t++) if (pick < 0 && m_fc[t]) pick = 2 + t;
      end
      if (pick >= 0) begin
        m_busy = 1; m_kind = pick; m_word = fmtDllp(pick, next_rcv_seq - 12'd1);
      end else if (acc) begin
        m_busy = 0;
      end
      m_age = (accNak || accAck || !m_ack) ? 0 : m_age + 1;
      base  = (accNak || accAck) ? 0 : m_cnt;
      m_cnt = good ? ((base + 1 > COAL) ? COAL : base + 1) : base;
      for (int t = 0; t < 3; t++)
        m_fc[t] = (m_fc[t] && !(acc && m_kind == 2 + t && pick < 0)) || wrap || fc_update_req[t];
      m_ack    = (m_ack && !(accNak || accAck)) || good;
      m_nak    = (m_nak && !accNak) || badEff;
      m_nsched = accNak ? 1'b1 : (good ? 1'b0 : m_nsched);
      m_tick   = wrap ? 0 : m_tick + 1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    modelStep();
  end

  always @(negedge clk) begin
    checkOutput("valid", 32'(dllp_valid), 32'(m_busy));
    if (m_busy || !rst) checkOutput("dllp_o", dllp_o, m_word);
    checkOutput("nak_scheduled", 32'(nak_scheduled), 32'(m_nsched));
    if (rst && dllp_valid && dllp_ready) seen.push_back(dllp_o);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit good, input bit bad, input logic [11:0] s,
                               input logic [2:0] fcreq);
    rx_tlp_good   = good;
    rx_tlp_bad    = bad;
    next_rcv_seq  = s;
    fc_update_req = fcreq;
    step();
    rx_tlp_good   = 1'b0;
    rx_tlp_bad    = 1'b0;
    fc_update_req = 3'b000;
  endtask

  task automatic waitValid(input int budget, output int n);
    n = 0;
    while (dllp_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    checkOutput("wait_valid", 32'(dllp_valid), 32'd1);
  endtask

  task automatic checkSeen(input string name, input int n,
                           input logic [31:0] w0, w1, w2, w3);
    logic [31:0] w[4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    checkOutput({name, "_count"}, 32'(seen.size()), 32'(n));
    for (int i = 0; i < n && i < seen.size(); i++) checkOutput(name, seen[i], w[i]);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_tlp_good   = 1'($urandom);
      rx_tlp_bad    = 1'($urandom);
      next_rcv_seq  = 12'($urandom);
      fc_update_req = 3'($urandom);
      dllp_ready    = 1'($urandom);
      p_hdr = 8'($urandom); np_hdr = 8'($urandom); cpl_hdr = 8'($urandom);
      p_data = 12'($urandom); np_data = 12'($urandom); cpl_data = 12'($urandom);
      step();
      checkOutput("rst_valid", 32'(dllp_valid), 32'd0);
      checkOutput("rst_dllp", dllp_o, 32'd0);
      checkOutput("rst_nak_sched", 32'(nak_scheduled), 32'd0);
    end

    rx_tlp_good = 1'b0; rx_tlp_bad = 1'b0; next_rcv_seq = 12'd0; fc_update_req = 3'b000;
    dllp_ready = 1'b1;
    p_hdr = 8'h20; p_data = 12'h100;
    np_hdr = 8'h11; np_data = 12'h222;
    cpl_hdr = 8'h33; cpl_data = 12'h444;
    seen.delete();
    rst = 1'b1;

    // First wrap of the FC timer is the only source of traffic after reset.
    waitValid(600, n);
    checkOutput("fc_first_cycle", 32'(n), 32'd513);
    checkOutput("fc_p_word", dllp_o, 32'h8008_0100);
    repeat (8) step();
    checkSeen("fc_wrap_order", 3, 32'h8008_0100, 32'hA004_4222, 32'hC00C_C444, 32'h0);

    seen.delete();
    applyStimulus(1'b1, 1'b0, 12'd5, 3'b000);
    waitValid(100, n);
    checkOutput("ack_latency", 32'(n), 32'd65);
    checkOutput("ack_lat_word", dllp_o, 32'h0000_0004);
    repeat (100) step();
    checkSeen("ack_lat_once", 1, 32'h0000_0004, 32'h0, 32'h0, 32'h0);

    seen.delete();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 1'b0, 12'(i), 3'b000);
    waitValid(10, n);
    checkOutput("coalesce_latency", 32'(n >= 1 && n <= 2), 32'd1);
    checkOutput("coalesce_word", dllp_o, 32'h0000_0003);
    repeat (5) step();
    checkSeen("coalesce_once", 1, 32'h0000_0003, 32'h0, 32'h0, 32'h0);

    seen.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 12'd0, 3'b000);
    waitValid(10, n);
    checkOutput("seq_wrap_word", dllp_o, 32'h0000_0FFF);
    repeat (5) step();
    checkSeen("seq_wrap_once", 1, 32'h0000_0FFF, 32'h0, 32'h0, 32'h0);

    seen.delete();
    applyStimulus(1'b0, 1'b1, 12'd9, 3'b000);
    repeat (3) step();
    applyStimulus(1'b0, 1'b1, 12'd9, 3'b000);
    repeat (10) step();
    checkSeen("nak_single", 1, 32'h1000_0008, 32'h0, 32'h0, 32'h0);
    checkOutput("nak_sched_set", 32'(nak_scheduled), 32'd1);

    seen.delete();
    applyStimulus(1'b1, 1'b0, 12'd10, 3'b000);
    applyStimulus(1'b0, 1'b1, 12'd10, 3'b000);
    repeat (80) step();
    checkSeen("nak_second", 1, 32'h1000_0009, 32'h0, 32'h0, 32'h0);

    // Nak, a coalesced Ack and all three UpdateFCs pile up behind a stalled arbiter.
    seen.delete();
    dllp_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 12'd20, 3'b000);
    applyStimulus(1'b0, 1'b1, 12'd20, 3'b000);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 12'd20, 3'b000);
    applyStimulus(1'b0, 1'b0, 12'd20, 3'b111);
    for (int i = 0; i < 10; i++) begin
      step();
      checkOutput("bp_valid", 32'(dllp_valid), 32'd1);
      checkOutput("bp_hold", dllp_o, 32'h1000_0013);
    end
    dllp_ready = 1'b1;
    repeat (20) step();
    checkSeen("bp_order", 4, 32'h1000_0013, 32'h8008_0100, 32'hA004_4222, 32'hC00C_C444);

    dllp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 12'd20, 3'b001);
    step();
    checkOutput("mid_send_valid", 32'(dllp_valid), 32'd1);
    rst = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(dllp_valid), 32'd0);
    checkOutput("rst_async_dllp", dllp_o, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    dllp_ready = 1'b1;
    seen.delete();
    repeat (50) step();
    checkSeen("rst_discard", 0, 32'h0, 32'h0, 32'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dllp_scheduler.md
# dllp_scheduler

Data link layer transmit-side scheduler that decides when Ack, Nak and UpdateFC DLLPs are generated and presents them one at a time to the TX arbiter's DLLP request port. It tracks receiver events (good and bad TLPs), the Ack latency and coalescing limits, and the periodic and on-demand flow-control update requirements. It formats the 32-bit DLLP body; CRC16 is appended downstream. It holds each DLLP stable until the arbiter accepts it.

## Interface
- ACK_LAT_LIMIT, 64: cycles an unacknowledged good TLP may wait before an Ack becomes due.
- ACK_COALESCE, 4: count of good TLPs since the last Ack/Nak that makes an Ack due immediately.
- FC_UPDATE_LIMIT, 512: period in cycles of the free-running UpdateFC timer.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- rx_tlp_good  in  1  pulse: received TLP passed LCRC and sequence check.
- rx_tlp_bad  in  1  pulse: received TLP failed LCRC or sequence check.
- next_rcv_seq  in  12  receiver NEXT_RCV_SEQ, already updated when rx_tlp_good is sampled.
- fc_update_req  in  3  per-type immediate UpdateFC request; bit0 = P, bit1 = NP, bit2 = Cpl.
- p_hdr, np_hdr, cpl_hdr  in  8 each  header credits to advertise.
- p_data, np_data, cpl_data  in  12 each  data credits to advertise.
- dllp_ready  in  1  arbiter can take a DLLP this cycle.
- dllp_valid  out  1  DLLP body valid; drives the arbiter's dllp_valid.
- dllp_o  out  32  DLLP body, byte0 in [31:24].
- nak_scheduled  out  1  status: Nak sent, no good TLP received since.

## Operation
- Pending flags: nak_pend, ack_pend, fc_pend[2:0]. When a set and a clear hit the same flag on the same edge, the set wins.
- rx_tlp_good:
  - Sets ack_pend.
  - Increments tlp_cnt, saturating at ACK_COALESCE.
  - Clears nak_scheduled.
- rx_tlp_bad:
  - Sets nak_pend only if nak_scheduled is 0; otherwise it is ignored.
  - If rx_tlp_good and rx_tlp_bad occur in the same cycle, rx_tlp_bad is treated as ignored.
- Ack timer:
  - Counts while ack_pend = 1 and saturates at ACK_LAT_LIMIT.
  - Held at 0 while ack_pend = 0.
  - Ack is due when timer == ACK_LAT_LIMIT or tlp_cnt == ACK_COALESCE.
- FC timer:
  - Free-running, 0 to FC_UPDATE_LIMIT-1.
  - On wrap, sets fc_pend = 3'b111.
  - fc_update_req ORs into fc_pend.
- Selection priority: Nak > due Ack > UpdateFC-P > UpdateFC-NP > UpdateFC-Cpl.
- Sequence field seq = next_rcv_seq - 1, modulo 4096 (0 becomes 0xFFF).
- DLLP formats:
  - Ack: {8'h00, 8'h00, 4'h0, seq}.
  - Nak: {8'h10, 8'h00, 4'h0, seq}.
  - UpdateFC: {type, 2'b00, hdr[7:0], 2'b00, data[11:0]}, with type 8'h80 (P), 8'hA0 (NP), 8'hC0 (Cpl), VC0.
- FSM, two states:
  - IDLE: if anything is selectable, register dllp_o and the selection code, set dllp_valid, go to SEND.
  - SEND: hold dllp_o and dllp_valid. On dllp_valid & dllp_ready, clear the selected flag, drop dllp_valid, return to IDLE.
- Effects of an accepted DLLP:
  - Nak accepted: clears nak_pend and ack_pend, zeroes tlp_cnt, sets nak_scheduled.
  - Ack accepted: clears ack_pend, zeroes tlp_cnt.
- Events arriving during SEND only update the flags. A higher-priority event never retracts or alters the DLLP being presented.

## Timing
- Reset values: dllp_valid 0, dllp_o 0, nak_scheduled 0; all flags, counters and both timers 0; FSM in IDLE.
- Reset asserted mid-SEND: dllp_valid drops asynchronously and the DLLP is discarded.
- Event pulse sampled at edge k: flag set at edge k. When in IDLE with the DLLP selectable (Nak or UpdateFC), dllp_valid rises at edge k+1.
- Accept at edge a: dllp_valid low after edge a. The next DLLP can be valid after edge a+1, giving a minimum spacing of one idle cycle.
- Credits and seq are sampled when dllp_o is loaded in IDLE, not at accept.
- An Ack is never issued while ack_pend = 0. The Ack timer restarts from 0 after an Ack is accepted.

## Test plan
- Reset: hold rst = 0 with random inputs -> dllp_valid = 0, dllp_o = 0, nak_scheduled = 0. Release -> no DLLP until FC timer wrap at cycle 512.
- Latency Ack: one rx_tlp_good with next_rcv_seq = 5, dllp_ready = 1 -> dllp_o = 32'h0000_0004 valid about 64 cycles later, exactly once.
- Coalesce: 4 back-to-back rx_tlp_good, next_rcv_seq 1..4 -> Ack 32'h0000_0003 within 2 cycles of the 4th pulse. next_rcv_seq = 0 -> seq 0xFFF.
- Nak suppression: rx_tlp_bad twice (next_rcv_seq = 9) -> a single Nak 32'h1000_0008, nak_scheduled = 1. Then rx_tlp_good followed by rx_tlp_bad -> a second Nak.
- Backpressure: dllp_ready = 0 for 10 cycles with a Nak, a due Ack and fc_update_req = 3'b111 pending -> dllp_o stable throughout. Order after release: Nak, UpdateFC-P, NP, Cpl; no Ack is sent, because the Nak cleared ack_pend.
- FC format: FC timer wrap with p_hdr = 8'h20, p_data = 12'h100 -> UpdateFC-P dllp_o = 32'h8008_0100, followed by NP and Cpl.
